// File: rtl/sha512_seq_ctrl_pkg.sv
// Shared definitions for the SHA-512 block sequencer.
// Contents:
//   SHA512_ROUNDS - rounds per compression (default core latency)
//   WORD_W/BLK_W/DIG_W - word, message block and digest widths
//   CNT_W         - round counter width (holds 0..SHA512_ROUNDS-1)
//   SHA512_IV     - initial hash value H(0), word a in the top 64 bits
//   state_e       - sequencer states
package sha512_seq_ctrl_pkg;

  localparam int unsigned SHA512_ROUNDS = 80;
  localparam int unsigned WORD_W        = 64;
  localparam int unsigned BLK_W         = 16 * WORD_W;
  localparam int unsigned DIG_W         = 8 * WORD_W;
  localparam int unsigned CNT_W         = 7;

  localparam logic [DIG_W-1:0] SHA512_IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/sha512_seq_ctrl_if.sv
// Host-side bus of the SHA-512 sequencer: message block input channel and
// digest output channel, both valid/ready.
//   blk_valid/blk_ready/blk_data/blk_first/blk_last - block channel
//   dig_valid/dig_ready/dig_data                    - digest channel
// master: host/DMA front end, slave: sequencer.
interface sha512_seq_ctrl_if;

  logic                                    blk_valid;
  logic                                    blk_ready;
  logic [sha512_seq_ctrl_pkg::BLK_W-1:0]   blk_data;
  logic                                    blk_first;
  logic                                    blk_last;
  logic                                    dig_valid;
  logic                                    dig_ready;
  logic [sha512_seq_ctrl_pkg::DIG_W-1:0]   dig_data;

  modport master (
    output blk_valid, blk_data, blk_first, blk_last, dig_ready,
    input  blk_ready, dig_valid, dig_data
  );

  modport slave (
    input  blk_valid, blk_data, blk_first, blk_last, dig_ready,
    output blk_ready, dig_valid, dig_data
  );

endinterface

// File: rtl/sha512_seq_ctrl.sv
// Sequencer for one sha512_block round engine. Accepts padded 1024-bit
// blocks, picks the chaining value (IV for a first block, previous result
// otherwise), holds message and chaining value stable for the whole
// compression, waits LATENCY cycles and either chains the result or
// presents it as the digest.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   bus (slave)     - block input / digest output handshakes
//   busy_o          - state != IDLE
//   core_start_o    - one-cycle start pulse to the core
//   core_M_o        - message block to the core
//   core_H_in_o     - chaining value to the core
//   core_H_out_i    - core result (H_in + working variables)
module sha512_seq_ctrl
  import sha512_seq_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = SHA512_ROUNDS
) (
  input  logic              clk,
  input  logic              rst,
  sha512_seq_ctrl_if.slave  bus,
  output logic              busy_o,
  output logic              core_start_o,
  output logic [BLK_W-1:0]  core_M_o,
  output logic [DIG_W-1:0]  core_H_in_o,
  input  logic [DIG_W-1:0]  core_H_out_i
);

  // Last RUN count value: the core output is final in this cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIG_W-1:0]   h_chain_q, h_chain_d;
  logic [DIG_W-1:0]   hin_q, hin_d;
  logic [BLK_W-1:0]   m_q, m_d;
  logic               last_q, last_d;
  logic               accept_s;
  logic               run_done_s;
  logic               blk_ready_s;
  logic               dig_valid_s;
  logic               core_start_s;
  logic               busy_s;

  assign accept_s   = (state_q == ST_IDLE) && bus.blk_valid;
  assign run_done_s = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  // State and datapath registers; reset also restores the IV so a message
  // interrupted by reset cannot leak into the next chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      h_chain_q <= SHA512_IV;
      hin_q     <= SHA512_IV;
      m_q       <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      h_chain_q <= h_chain_d;
      hin_q     <= hin_d;
      m_q       <= m_d;
      last_q    <= last_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_START;
        else          state_d = ST_IDLE;
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (run_done_s) state_d = last_q ? ST_OUT : ST_IDLE;
        else            state_d = ST_RUN;
      end
      ST_OUT: begin
        if (bus.dig_ready) state_d = ST_IDLE;
        else               state_d = ST_OUT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: operands change only on accept, result only on
  // the final RUN cycle.
  always_comb begin
    m_d       = m_q;
    hin_d     = hin_q;
    last_d    = last_q;
    h_chain_d = h_chain_q;
    cnt_d     = cnt_q;
    if (accept_s) begin
      m_d    = bus.blk_data;
      hin_d  = bus.blk_first ? SHA512_IV : h_chain_q;
      last_d = bus.blk_last;
    end else begin
      m_d    = m_q;
    end
    if (state_q == ST_START)    cnt_d = '0;
    else if (state_q == ST_RUN) cnt_d = cnt_q + 7'd1;
    else                        cnt_d = cnt_q;
    if (run_done_s) h_chain_d = core_H_out_i;
    else            h_chain_d = h_chain_q;
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    blk_ready_s  = 1'b0;
    dig_valid_s  = 1'b0;
    core_start_s = 1'b0;
    busy_s       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        blk_ready_s = 1'b1;
        busy_s      = 1'b0;
      end
      ST_START: core_start_s = 1'b1;
      ST_RUN:   busy_s       = 1'b1;
      ST_OUT:   dig_valid_s  = 1'b1;
      default: begin
        blk_ready_s = 1'b0;
        busy_s      = 1'b1;
      end
    endcase
  end

  assign bus.blk_ready = blk_ready_s;
  assign bus.dig_valid = dig_valid_s;
  assign bus.dig_data  = h_chain_q;
  assign busy_o        = busy_s;
  assign core_start_o  = core_start_s;
  assign core_M_o      = m_q;
  assign core_H_in_o   = hin_q;

endmodule

// File: tb/tb_sha512_seq_ctrl.sv
// Directed bench for sha512_seq_ctrl. A behavioural round engine in this
// module stands in for sha512_block: one round per cycle starting on the
// core_start edge, reading core_M/core_H_in live, so the result is final
// LATENCY cycles after the start cycle.
module tb_sha512_seq_ctrl;
  import sha512_seq_ctrl_pkg::*;

  localparam int LAT = 80;

  localparam logic [63:0] K [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [895:0]  NIST_MSG =
    "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";
  localparam logic [1023:0] ABC_BLK  = {24'h616263, 8'h80, 864'h0, 128'd24};
  localparam logic [1023:0] NIST_B1  = {NIST_MSG, 8'h80, 120'h0};
  localparam logic [1023:0] NIST_B2  = {896'h0, 128'd896};
  localparam logic [511:0]  ABC_DIG  = {
    64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
  localparam logic [511:0]  NIST_DIG = {
    64'h8e959b75dae313da, 64'h8cf4f72814fc143f, 64'h8f7779c6eb9f7fa1, 64'h7299aeadb6889018,
    64'h501d289e4900f7e4, 64'h331b99dec4b5433a, 64'hc7d329eeb6dd2654, 64'h5e96e55b874be909};

  logic           clk = 1'b0;
  logic           rst;
  logic           busy;
  logic           core_start;
  logic [1023:0]  core_M;
  logic [511:0]   core_H_in;
  logic [511:0]   core_H_out;
  int             n_total = 0;
  int             n_pass  = 0;

  sha512_seq_ctrl_if bus_if ();

  sha512_seq_ctrl #(.LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .busy_o       (busy),
    .core_start_o (core_start),
    .core_M_o     (core_M),
    .core_H_in_o  (core_H_in),
    .core_H_out_i (core_H_out)
  );

  always #5 clk = ~clk;

  // SHA-512 reference functions
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [79:0][63:0] sched(input logic [1023:0] m);
    logic [79:0][63:0] w;
    logic [15:0][63:0] mw;
    logic [63:0] s0, s1;
    mw = m;
    for (int t = 0; t < 16; t++) w[t] = mw[15 - t];
    for (int t = 16; t < 80; t++) begin
      s0 = rotr(w[t-15], 1) ^ rotr(w[t-15], 8) ^ (w[t-15] >> 7);
      s1 = rotr(w[t-2], 19) ^ rotr(w[t-2], 61) ^ (w[t-2] >> 6);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    return w;
  endfunction

  function automatic logic [511:0] rnd(input logic [511:0] v, input logic [63:0] k, input logic [63:0] w);
    logic [63:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = v;
    t1 = h + (rotr(e, 14) ^ rotr(e, 18) ^ rotr(e, 41)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 28) ^ rotr(a, 34) ^ rotr(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [511:0] add8(input logic [511:0] x, input logic [511:0] y);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = x[64*i +: 64] + y[64*i +: 64];
    return r;
  endfunction

  function automatic logic [511:0] compress(input logic [511:0] h, input logic [1023:0] m);
    logic [79:0][63:0] w;
    logic [511:0] v;
    w = sched(m);
    v = h;
    for (int t = 0; t < 80; t++) v = rnd(v, K[t], w[t]);
    return add8(h, v);
  endfunction

  // Behavioural round engine: round 0 on the start edge, then one per cycle.
  logic [79:0][63:0] core_w;
  logic [511:0]      cv_q = '0;
  int                cr_q = 80;

  assign core_w     = sched(core_M);
  assign core_H_out = add8(core_H_in, cv_q);

  always @(posedge clk) begin
    if (core_start) begin
      cv_q <= rnd(core_H_in, K[0], core_w[0]);
      cr_q <= 1;
    end else if (cr_q < 80) begin
      cv_q <= rnd(cv_q, K[cr_q], core_w[cr_q]);
      cr_q <= cr_q + 1;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Offers a block at the current negedge (cycle 0) and follows it to the
  // last RUN cycle (cycle LAT+1). With hold set, blk_valid stays high and
  // blk_data/first/last switch to the next block after cycle 0.
  task automatic send_block(input string tag, input logic [1023:0] m, input logic first,
                            input logic last, input logic [511:0] exp_hin, input logic hold,
                            input logic [1023:0] m_nxt, input logic first_nxt, input logic last_nxt);
    int n_start = 0;
    int n_dig   = 0;
    int n_rdy   = 0;
    int n_tog   = 0;
    bus_if.blk_valid = 1'b1;
    bus_if.blk_data  = m;
    bus_if.blk_first = first;
    bus_if.blk_last  = last;
    chk1({tag, " blk_ready at accept"}, bus_if.blk_ready, 1'b1);
    @(negedge clk);
    if (hold) begin
      bus_if.blk_data  = m_nxt;
      bus_if.blk_first = first_nxt;
      bus_if.blk_last  = last_nxt;
    end else begin
      bus_if.blk_valid = 1'b0;
    end
    chk1({tag, " core_start"}, core_start, 1'b1);
    chkw({tag, " core_M hi"}, core_M[1023:512], m[1023:512]);
    chkw({tag, " core_M lo"}, core_M[511:0], m[511:0]);
    chkw({tag, " core_H_in"}, core_H_in, exp_hin);
    for (int k = 2; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (core_start) n_start++;
      if (bus_if.dig_valid) n_dig++;
      if (bus_if.blk_ready) n_rdy++;
      if (core_M !== m || core_H_in !== exp_hin) n_tog++;
    end
    chki({tag, " extra core_start"}, n_start, 0);
    chki({tag, " early dig_valid"}, n_dig, 0);
    chki({tag, " blk_ready during run"}, n_rdy, 0);
    chki({tag, " operand toggles"}, n_tog, 0);
  endtask

  logic [511:0] held;
  logic [511:0] h1;
  int           n_bad;

  initial begin
    rst              = 1'b1;
    bus_if.blk_valid = 1'b0;
    bus_if.blk_data  = '0;
    bus_if.blk_first = 1'b0;
    bus_if.blk_last  = 1'b0;
    bus_if.dig_ready = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) @(negedge clk);
    chk1("rst blk_ready", bus_if.blk_ready, 1'b1);
    chk1("rst dig_valid", bus_if.dig_valid, 1'b0);
    chk1("rst core_start", core_start, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chkw("rst core_H_in", core_H_in, SHA512_IV);
    rst = 1'b0;
    @(negedge clk);

    // Single-block "abc", then 10 cycles of digest backpressure.
    send_block("abc", ABC_BLK, 1'b1, 1'b1, SHA512_IV, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("abc dig_valid at accept+82", bus_if.dig_valid, 1'b1);
    chkw("abc digest", bus_if.dig_data, ABC_DIG);
    chk1("abc blk_ready in OUT", bus_if.blk_ready, 1'b0);
    held  = bus_if.dig_data;
    n_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.dig_valid !== 1'b1 || bus_if.dig_data !== held || bus_if.blk_ready !== 1'b0) n_bad++;
    end
    chki("backpressure hold", n_bad, 0);
    bus_if.dig_ready = 1'b1;
    @(negedge clk);
    bus_if.dig_ready = 1'b0;
    chk1("release dig_valid", bus_if.dig_valid, 1'b0);
    chk1("release blk_ready", bus_if.blk_ready, 1'b1);
    chk1("release busy", busy, 1'b0);

    // Two-block NIST message; blk_valid held through block 1's run.
    h1 = compress(SHA512_IV, NIST_B1);
    send_block("nist b1", NIST_B1, 1'b1, 1'b0, SHA512_IV, 1'b1, NIST_B2, 1'b0, 1'b1);
    @(negedge clk);
    chk1("nist b1 no digest", bus_if.dig_valid, 1'b0);
    send_block("nist b2", NIST_B2, 1'b0, 1'b1, h1, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("nist dig_valid", bus_if.dig_valid, 1'b1);
    chkw("nist digest", bus_if.dig_data, NIST_DIG);
    bus_if.dig_ready = 1'b1;
    @(negedge clk);
    bus_if.dig_ready = 1'b0;
    chk1("nist release blk_ready", bus_if.blk_ready, 1'b1);

    // Reset in the RUN cycle where cnt==40 (cycle 42 after accept).
    bus_if.blk_valid = 1'b1;
    bus_if.blk_data  = ABC_BLK;
    bus_if.blk_first = 1'b1;
    bus_if.blk_last  = 1'b1;
    @(negedge clk);
    bus_if.blk_valid = 1'b0;
    repeat (41) @(negedge clk);
    chk1("mid-run busy before reset", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("mid-run rst busy", busy, 1'b0);
    chk1("mid-run rst blk_ready", bus_if.blk_ready, 1'b1);
    chkw("mid-run rst chain is IV", bus_if.dig_data, SHA512_IV);
    n_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_if.dig_valid !== 1'b0 || busy !== 1'b0) n_bad++;
    end
    chki("mid-run rst no digest", n_bad, 0);

    // Non-first block right after reset must chain from the restored IV.
    send_block("abc after rst", ABC_BLK, 1'b0, 1'b1, SHA512_IV, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("abc after rst dig_valid", bus_if.dig_valid, 1'b1);
    chkw("abc after rst digest", bus_if.dig_data, ABC_DIG);
    bus_if.dig_ready = 1'b1;
    @(negedge clk);
    bus_if.dig_ready = 1'b0;
    chk1("abc after rst release", bus_if.blk_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
